alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback stage wrapped around the processor ALU.
// Define ALU_OVF_FLAG_EN to add the ovf_out overflow flag.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int WIDTH         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic             req_use_acc,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    output logic [WIDTH-1:0] ac_out,
    output logic             z_out,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic             halted
`ifdef ALU_OVF_FLAG_EN
    ,
    output logic             ovf_out
`endif
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_PASA = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        HALT
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       z_next;

    assign z_next = (alu_sel == OP_ADD || alu_sel == OP_SUB)
                  ? alu_z : (alu_out == '0);

`ifdef ALU_OVF_FLAG_EN
    logic [2*WIDTH-1:0] prod;
    logic               sa;
    logic               sb;
    logic               sr;
    logic               ovf_next;

    assign prod = {{WIDTH{1'b0}}, alu_a} * {{WIDTH{1'b0}}, alu_b};
    assign sa   = alu_a[WIDTH-1];
    assign sb   = alu_b[WIDTH-1];
    assign sr   = alu_out[WIDTH-1];

    always_comb begin
        ovf_next = 1'b0;
        unique case (1'b1)
            (alu_sel == OP_ADD):  ovf_next = (sa == sb) && (sr != sa);
            (alu_sel == OP_SUB):  ovf_next = (sa != sb) && (sr != sa);
            (alu_sel == OP_MULT): ovf_next = |prod[2*WIDTH-1:WIDTH];
            default:              ovf_next = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_PASA;
            ac_out    <= '0;
            z_out     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            halted    <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            ovf_out   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        unique case (1'b1)
                            (req_op == OP_HALT): begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                            (req_op == OP_ILL): begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                            default: begin
                                state   <= ISSUE;
                                cnt     <= CNT_INIT;
                                alu_a   <= req_use_acc ? ac_out : req_a;
                                alu_b   <= req_b;
                                alu_sel <= req_op;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        ac_out    <= alu_out;
                        z_out     <= z_next;
                        rsp_valid <= 1'b1;
`ifdef ALU_OVF_FLAG_EN
                        ovf_out   <= ovf_next;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with SETTLE_CYCLES=1 and =4 instances.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n4 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid4 = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic        req_use_acc = 1'b0;
    logic [15:0] req_a = 16'h0;
    logic [15:0] req_b = 16'h0;

    logic        req_ready, rsp_valid, rsp_err, halted, z_out, alu_z;
    logic [15:0] alu_a, alu_b, alu_out, ac_out;
    logic [2:0]  alu_sel;

    logic        req_ready4, rsp_valid4, rsp_err4, halted4, z_out4, alu_z4;
    logic [15:0] alu_a4, alu_b4, alu_out4, ac_out4;
    logic [2:0]  alu_sel4;
`ifdef ALU_OVF_FLAG_EN
    logic        ovf_out, ovf_out4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference model of the external ALU the stage drives.
    function automatic logic [16:0] alu_m(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [2:0]  s);
        logic [15:0] r;
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        case (s)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = p[15:0];
            3'd3:    r = a;
            3'd4:    r = b;
            default: r = 16'h0;
        endcase
        return {r == 16'h0, r};
    endfunction

    assign {alu_z, alu_out}   = alu_m(alu_a, alu_b, alu_sel);
    assign {alu_z4, alu_out4} = alu_m(alu_a4, alu_b4, alu_sel4);

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_ready(req_ready), .req_op(req_op),
        .req_use_acc(req_use_acc), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_z(alu_z), .ac_out(ac_out),
        .z_out(z_out), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .halted(halted)
`ifdef ALU_OVF_FLAG_EN
        , .ovf_out(ovf_out)
`endif
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(4), .WIDTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n4), .req_valid(req_valid4),
        .req_ready(req_ready4), .req_op(req_op),
        .req_use_acc(req_use_acc), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4),
        .alu_out(alu_out4), .alu_z(alu_z4), .ac_out(ac_out4),
        .z_out(z_out4), .rsp_valid(rsp_valid4), .rsp_err(rsp_err4),
        .halted(halted4)
`ifdef ALU_OVF_FLAG_EN
        , .ovf_out(ovf_out4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake on the SETTLE_CYCLES=1 instance, then one more edge:
    // returns sampling the RESP cycle.
    task automatic run_op(input logic [2:0] op, input logic use_acc,
                          input logic [15:0] a, input logic [15:0] b);
        req_op = op;
        req_use_acc = use_acc;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst_n4 = 1'b0;
        req_valid = 1'b1;
        req_op = 3'b000;
        req_a = 16'h1111;
        req_b = 16'h2222;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (ac_out !== 16'h0 || z_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ac: got %h/%b expected 0000/0",
                     ac_out, z_out);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b%b%b expected 000",
                     rsp_valid, rsp_err, halted);
        end
        checks++;
        if (alu_sel !== 3'b011 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            errors++;
            $display("FAIL reset_alu: got %b %h %h expected 011 0000 0000",
                     alu_sel, alu_a, alu_b);
        end
        checks++;
        if (req_ready4 !== 1'b1 || ac_out4 !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut4: got %b %h expected 1 0000",
                     req_ready4, ac_out4);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        rst_n4 = 1'b1;
        tick();
    endtask

    task automatic test_add();
        req_op = 3'b000;
        req_use_acc = 1'b0;
        req_a = 16'h0003;
        req_b = 16'h0004;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_issue: got ready %b rsp %b expected 0 0",
                     req_ready, rsp_valid);
        end
        checks++;
        if (alu_a !== 16'h0003 || alu_b !== 16'h0004 || alu_sel !== 3'b000)
        begin
            errors++;
            $display("FAIL add_drive: got %h %h %b expected 0003 0004 000",
                     alu_a, alu_b, alu_sel);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b0)
        begin
            errors++;
            $display("FAIL add_rsp: got %b%b%b expected 100",
                     rsp_valid, rsp_err, req_ready);
        end
        checks++;
        if (ac_out !== 16'h0007 || z_out !== 1'b0) begin
            errors++;
            $display("FAIL add_ac: got %h/%b expected 0007/0", ac_out, z_out);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_idle: got rsp %b ready %b expected 0 1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_dependent();
        run_op(3'b001, 1'b0, 16'h1234, 16'h1234);
        checks++;
        if (ac_out !== 16'h0000 || z_out !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: got %h/%b/%b expected 0000/1/1",
                     ac_out, z_out, rsp_valid);
        end
        tick();
        req_op = 3'b000;
        req_use_acc = 1'b1;
        req_a = 16'h5555;
        req_b = 16'hFFFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a = 16'hAAAA;
        req_b = 16'h1357;
        checks++;
        if (alu_a !== 16'h0000 || alu_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL acc_drive: got %h %h expected 0000 ffff",
                     alu_a, alu_b);
        end
        tick();
        checks++;
        if (ac_out !== 16'hFFFF || z_out !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL acc_add: got %h/%b/%b expected ffff/0/1",
                     ac_out, z_out, rsp_valid);
        end
        checks++;
        if (alu_a !== 16'h0000 || alu_b !== 16'hFFFF || alu_sel !== 3'b000)
        begin
            errors++;
            $display("FAIL acc_hold: got %h %h %b expected 0000 ffff 000",
                     alu_a, alu_b, alu_sel);
        end
        req_use_acc = 1'b0;
        tick();
    endtask

    task automatic test_mult_ovf();
        run_op(3'b010, 1'b0, 16'h0100, 16'h0100);
        checks++;
        if (ac_out !== 16'h0000 || z_out !== 1'b1) begin
            errors++;
            $display("FAIL mult: got %h/%b expected 0000/1", ac_out, z_out);
        end
`ifdef ALU_OVF_FLAG_EN
        checks++;
        if (ovf_out !== 1'b1) begin
            errors++;
            $display("FAIL mult_ovf: got %b expected 1", ovf_out);
        end
`endif
        tick();
        run_op(3'b000, 1'b0, 16'h7FFF, 16'h0001);
        checks++;
        if (ac_out !== 16'h8000 || z_out !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: got %h/%b expected 8000/0", ac_out, z_out);
        end
`ifdef ALU_OVF_FLAG_EN
        checks++;
        if (ovf_out !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf: got %b expected 1", ovf_out);
        end
`endif
        tick();
        run_op(3'b100, 1'b0, 16'h9999, 16'h00AB);
        checks++;
        if (ac_out !== 16'h00AB || z_out !== 1'b0) begin
            errors++;
            $display("FAIL pass_b: got %h/%b expected 00ab/0", ac_out, z_out);
        end
`ifdef ALU_OVF_FLAG_EN
        checks++;
        if (ovf_out !== 1'b0) begin
            errors++;
            $display("FAIL pass_ovf: got %b expected 0", ovf_out);
        end
`endif
        tick();
        run_op(3'b101, 1'b0, 16'h1234, 16'h5678);
        checks++;
        if (ac_out !== 16'h0000 || z_out !== 1'b1) begin
            errors++;
            $display("FAIL zero_op: got %h/%b expected 0000/1", ac_out, z_out);
        end
        tick();
        run_op(3'b011, 1'b0, 16'h1234, 16'h0000);
        checks++;
        if (ac_out !== 16'h1234 || z_out !== 1'b0) begin
            errors++;
            $display("FAIL pass_a: got %h/%b expected 1234/0", ac_out, z_out);
        end
        tick();
    endtask

    task automatic test_illegal();
        req_op = 3'b111;
        req_a = 16'hDEAD;
        req_b = 16'hBEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ill_rsp: got %b%b%b expected 110",
                     rsp_valid, rsp_err, req_ready);
        end
        checks++;
        if (ac_out !== 16'h1234 || z_out !== 1'b0) begin
            errors++;
            $display("FAIL ill_ac: got %h/%b expected 1234/0", ac_out, z_out);
        end
        checks++;
        if (alu_sel !== 3'b011 || alu_a !== 16'h1234) begin
            errors++;
            $display("FAIL ill_drive: got %b %h expected 011 1234",
                     alu_sel, alu_a);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ill_end: got %b%b%b expected 001",
                     rsp_valid, rsp_err, req_ready);
        end
    endtask

    task automatic test_halt();
        req_op = 3'b110;
        req_valid = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: got %b%b%b expected 100",
                     halted, req_ready, rsp_valid);
        end
        req_op = 3'b000;
        req_a = 16'h0001;
        req_b = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (halted !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0)
            begin
                errors++;
                $display("FAIL halt_hold: cycle %0d got %b%b%b expected 100",
                         i, halted, req_ready, rsp_valid);
            end
        end
        checks++;
        if (ac_out !== 16'h1234 || alu_sel !== 3'b011) begin
            errors++;
            $display("FAIL halt_state: got %h %b expected 1234 011",
                     ac_out, alu_sel);
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (halted !== 1'b0 || req_ready !== 1'b1 || ac_out !== 16'h0) begin
            errors++;
            $display("FAIL halt_reset: got %b %b %h expected 0 1 0000",
                     halted, req_ready, ac_out);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        int n_rsp = 0;
        int last = 0;
        logic prev_rsp = 1'b0;
        req_use_acc = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid) begin
                n_rsp++;
                checks++;
                if (prev_rsp) begin
                    errors++;
                    $display("FAIL b2b_width: rsp_valid wide at cycle %0d", k);
                end
            end
            prev_rsp = rsp_valid;
            if (req_ready) begin
                if (n_acc > 0) begin
                    checks++;
                    if (k - last != 3) begin
                        errors++;
                        $display("FAIL b2b_gap: got %0d expected 3", k - last);
                    end
                end
                last = k;
                req_op = n_acc[0] ? 3'b001 : 3'b000;
                req_b = n_acc[0] ? 16'h0002 : 16'h0005;
                n_acc++;
            end
            tick();
        end
        req_valid = 1'b0;
        req_use_acc = 1'b0;
        checks++;
        if (n_acc != 10 || n_rsp != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d/%0d expected 10/10",
                     n_acc, n_rsp);
        end
        checks++;
        if (ac_out !== 16'h000F) begin
            errors++;
            $display("FAIL b2b_ac: got %h expected 000f", ac_out);
        end
        tick();
    endtask

    task automatic test_settle4_reset();
        req_op = 3'b000;
        req_a = 16'h0010;
        req_b = 16'h0020;
        req_valid4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        req_a = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid4 !== 1'b0 || alu_a4 !== 16'h0010) begin
                errors++;
                $display("FAIL s4_issue: cycle %0d got %b %h expected 0 0010",
                         i, rsp_valid4, alu_a4);
            end
            tick();
        end
        checks++;
        if (rsp_valid4 !== 1'b1 || ac_out4 !== 16'h0030) begin
            errors++;
            $display("FAIL s4_rsp: got %b %h expected 1 0030",
                     rsp_valid4, ac_out4);
        end
        tick();
        req_op = 3'b001;
        req_a = 16'h0050;
        req_b = 16'h0010;
        req_valid4 = 1'b1;
        tick();
        req_valid4 = 1'b0;
        tick();
        tick();
        rst_n4 = 1'b0;
        tick();
        checks++;
        if (ac_out4 !== 16'h0 || z_out4 !== 1'b0 || alu_sel4 !== 3'b011) begin
            errors++;
            $display("FAIL s4_reset: got %h %b %b expected 0000 0 011",
                     ac_out4, z_out4, alu_sel4);
        end
        checks++;
        if (rsp_valid4 !== 1'b0 || req_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL s4_reset_hs: got %b %b expected 0 1",
                     rsp_valid4, req_ready4);
        end
        rst_n4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (rsp_valid4 !== 1'b0 || rsp_err4 !== 1'b0 || halted4 !== 1'b0)
            begin
                errors++;
                $display("FAIL s4_dropped: cycle %0d got %b%b%b expected 000",
                         i, rsp_valid4, rsp_err4, halted4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_dependent();
        test_mult_ovf();
        test_illegal();
        test_halt();
        test_back_to_back();
        test_settle4_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
